// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the mips_muldiv block.
// Contents:
//   op_e     - operation encoding driven on the op input
//   state_e  - sequencer states IDLE / RUN / FIX
//   WIDTH    - datapath width
//   ITER     - number of shift iterations per operation
//   op_is_div / op_is_signed - decode helpers for an op value
package mips_muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// Bus bundle between the datapath/control unit and the mul/div unit.
// Signals:
//   start, op, a, b      - operation launch and operands
//   hi_we, lo_we, wdata  - MTHI / MTLO writes
//   hi, lo               - architectural HI / LO
//   busy, done, div_zero - status back to control
// Modports: master (datapath side), slave (mul/div unit).
interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mips_muldiv_iter.sv
// One combinational iteration of the shift-add multiplier or the
// restoring shift-subtract divider.
// Ports:
//   mode_div_i - 0: multiply step, 1: divide step
//   acc_i      - upper half of the working register (partial product / remainder)
//   in_bit_i   - multiply: current multiplier LSB; divide: next dividend MSB
//   opnd_i     - multiplicand / divisor
//   acc_o      - next upper half
//   q_bit_o    - multiply: bit shifted into the lower half; divide: quotient bit
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             mode_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic             in_bit_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             q_bit_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_i} + (in_bit_i ? {1'b0, opnd_i} : '0);
        shifted = {acc_i, in_bit_i};
        // Remainder is always below the divisor, so the MSB of diff is a
        // true borrow flag: set exactly when shifted < divisor.
        diff    = shifted - {1'b0, opnd_i};
        acc_o   = sum[WIDTH:1];
        q_bit_o = sum[0];
        if (mode_div_i) begin
            if (!diff[WIDTH]) begin
                acc_o   = diff[WIDTH-1:0];
                q_bit_o = 1'b1;
            end else begin
                acc_o   = shifted[WIDTH-1:0];
                q_bit_o = 1'b0;
            end
        end
    end
endmodule

// File: rtl/mips_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - mips_muldiv_if.slave (operation launch, MTHI/MTLO, HI/LO, status)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO accepted when start=0
// RUN   | one shift iteration per cycle, WIDTH iterations
// FIX   | sign/zero fix-up, write HI/LO, pulse done
module mips_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    mips_muldiv_if.slave  bus
);
    import mips_muldiv_pkg::*;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               sign_a_q, sign_a_d;
    logic               b_zero_q, b_zero_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic               start_div, start_signed;
    logic               sa, sb;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               iter_in_bit;
    logic [WIDTH-1:0]   iter_acc;
    logic               iter_q_bit;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    assign start_div    = op_is_div(bus.op);
    assign start_signed = op_is_signed(bus.op);
    assign sa           = start_signed & bus.a[WIDTH-1];
    assign sb           = start_signed & bus.b[WIDTH-1];
    assign a_mag        = sa ? -bus.a : bus.a;
    assign b_mag        = sb ? -bus.b : bus.b;

    // Multiply walks the multiplier LSB-first; divide feeds dividend MSB-first.
    assign iter_in_bit  = is_div_q ? acc_lo_q[WIDTH-1] : acc_lo_q[0];

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .mode_div_i (is_div_q),
        .acc_i      (acc_hi_q),
        .in_bit_i   (iter_in_bit),
        .opnd_i     (opnd_q),
        .acc_o      (iter_acc),
        .q_bit_o    (iter_q_bit)
    );

    assign prod_fix = neg_q    ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    assign quo_fix  = neg_q    ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = sign_a_q ? -acc_hi_q : acc_hi_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        a_raw_d    = a_raw_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        sign_a_d   = sign_a_q;
        b_zero_d   = b_zero_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_div_d   = start_div;
                    neg_d      = sa ^ sb;
                    sign_a_d   = sa;
                    b_zero_d   = (bus.b == '0);
                    a_raw_d    = bus.a;
                    acc_hi_d   = '0;
                    // Multiply: multiplier in the low half, multiplicand as operand.
                    // Divide: dividend in the low half, divisor as operand.
                    acc_lo_d   = start_div ? a_mag : b_mag;
                    opnd_d     = start_div ? b_mag : a_mag;
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    state_d    = RUN;
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            RUN: begin
                acc_hi_d = iter_acc;
                acc_lo_d = is_div_q ? {acc_lo_q[WIDTH-2:0], iter_q_bit}
                                    : {iter_q_bit, acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = FIX;
            end
            FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (b_zero_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                div_zero_d = is_div_q & b_zero_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            sign_a_q   <= 1'b0;
            b_zero_q   <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            a_raw_q    <= a_raw_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            sign_a_q   <= sign_a_d;
            b_zero_q   <= b_zero_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: directed cases followed by random operations
// compared against an arithmetic reference model.
module tb_mips_muldiv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mips_muldiv_if #(.WIDTH(32)) bus ();

    mips_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: {div_zero, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        logic [31:0]     hi, lo;
        logic            dz;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin p = sa * sb; {hi, lo} = p; end
            2'b01: begin up = ua * ub; {hi, lo} = up; end
            2'b10: begin
                if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1; end
                else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
            end
            default: begin
                if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1; end
                else begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
            end
        endcase
        return {dz, hi, lo};
    endfunction

    // Caller must be at a negedge; start is driven for the very next edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz,
                          input bit disturb, input string tag);
        int n;
        int busy_n;
        bit seen;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (disturb) begin
            bus.hi_we = 1'b1;
            bus.lo_we = 1'b1;
            bus.wdata = 32'h1111_1111;
        end
        n = 0;
        busy_n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.busy === 1'b1) busy_n++;
            if (n == 1) begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
                bus.a = $urandom;
                bus.b = $urandom;
                chk({tag, " busy@1"}, 32'(bus.busy), 32'd1);
                chk({tag, " done@1"}, 32'(bus.done), 32'd0);
                chk({tag, " dz_clr"}, 32'(bus.div_zero), 32'd0);
            end
            if (disturb && n == 5) begin
                bus.start = 1'b1;
                bus.op    = 2'b10;
                bus.a     = $urandom;
                bus.b     = 32'd0;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = 32'hDEAD_BEEF;
            end
            if (disturb && n == 6) begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
            end
            if (n == 20) begin
                chk({tag, " hi_hold"}, bus.hi, m_hi);
                chk({tag, " lo_hold"}, bus.lo, m_lo);
            end
            if (bus.done === 1'b1) seen = 1'b1;
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL %s timeout: observed no done expected done within 100 cycles", tag);
        end
        if (seen) begin
            chk({tag, " latency"}, 32'(n), 32'd34);
            chk({tag, " busy_cyc"}, 32'(busy_n), 32'd33);
            chk({tag, " hi"}, bus.hi, eh);
            chk({tag, " lo"}, bus.lo, el);
            chk({tag, " div_zero"}, 32'(bus.div_zero), 32'(edz));
        end
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        logic [64:0] r;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          sel;
        int          dones;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst hi", bus.hi, 32'd0);
        chk("rst lo", bus.lo, 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst dz", 32'(bus.div_zero), 32'd0);
        rst_n = 1'b1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, "mult_neg");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, "div_neg");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, "divu");
        run_op(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0, "divu_zero");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, "div_ovf");
        run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1, "multu_busy");

        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        chk("mt both hi", bus.hi, 32'hDEAD_BEEF);
        chk("mt both lo", bus.lo, 32'hDEAD_BEEF);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0BAD_F00D;
        @(negedge clk);
        bus.hi_we = 1'b0;
        chk("mthi hi", bus.hi, 32'h0BAD_F00D);
        chk("mthi lo", bus.lo, 32'hDEAD_BEEF);
        m_hi = 32'h0BAD_F00D;
        m_lo = 32'hDEAD_BEEF;

        // Reset at RUN iteration 10 discards the operation.
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = $urandom;
        bus.b     = $urandom;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst hi", bus.hi, 32'd0);
        chk("midrst lo", bus.lo, 32'd0);
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        m_hi = '0;
        m_lo = '0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        chk("midrst no_done", 32'(dones), 32'd0);

        ra = 32'hFFFF_FF00;
        rb = 32'd3;
        r = model(2'b00, ra, rb);
        run_op(2'b00, ra, rb, r[63:32], r[31:0], r[64], 1'b0, "post_rst");

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            r = model(rop, ra, rb);
            run_op(rop, ra, rb, r[63:32], r[31:0], r[64], 1'b0, $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        chk("final done_pulse", 32'(bus.done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the mips32 datapath.
- Sits directly downstream of the ALU operand-select 2:1 muxes. It consumes the same rs operand and the mux-selected second operand as the ALU.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO to the writeback mux (MFHI/MFLO) and a busy flag the control unit uses to stall.

Parameters:
- WIDTH, 32, operand/HI/LO width. Only 32 is verified.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  launch operation `op`. Sampled only when busy=0.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  second operand from operand mux (multiplier / divisor).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in progress (state != IDLE).
- done  output  1  one-cycle pulse: HI/LO updated by a completed op.
- div_zero  output  1  registered with done: completed DIV/DIVU had b==0.

Behaviour:
- Reset (rst_n=0 at a rising edge): hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0. This applies mid-operation too; the partial result is discarded.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge k:
  - Latch op.
  - Signed ops: latch |a| and |b| plus sign bits. Unsigned ops: latch raw a and b.
  - Clear accumulator, counter=0, go to RUN.
  - start=0: stay in IDLE.
- RUN: one iteration per edge, 32 iterations at edges k+1..k+32, then go to FIX.
  - Multiply: shift-add, 64-bit product register.
  - Divide: restoring shift-subtract, 32-bit remainder and quotient.
- FIX, edge k+33: write the results below, pulse done=1 for exactly one cycle, go to IDLE.
  - Multiply: hi/lo = product; negated (two's complement, 64-bit) if sign_a ^ sign_b on MULT.
  - Divide: lo = quotient, negated if sign_a ^ sign_b on DIV. hi = remainder, negated if sign_a on DIV.
- Latency: done is visible in the cycle after edge k+33. busy is high from after edge k through the cycle in which done is high (excluded).
- Back-to-back: start may be asserted in the done cycle. It is accepted (state is IDLE).
- start while busy: ignored, with no effect on the in-flight op.
- Divide by zero (b==0, DIV or DIVU): full latency still applies. At FIX: hi = original a, lo = 0xFFFFFFFF, div_zero=1. div_zero is cleared on the next accepted start.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- MTHI/MTLO:
  - Effective only in IDLE with start=0: hi<=wdata / lo<=wdata at that edge.
  - hi_we and lo_we together write both.
  - Ignored while busy or when start=1 in the same cycle (start wins).
- Operand inputs a/b/op are don't-care except at the start-accept edge.
- Outputs hi/lo hold their old values during RUN. They change only at FIX, MTHI/MTLO or reset.

Decomposition:
- Package mips_muldiv_pkg:
  - Op encodings OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11.
  - State encodings IDLE/RUN/FIX.
  - Constants WIDTH=32 and ITER=32.
- One sub-module: muldiv_iter. Purely combinational single step:
  - Inputs: mode, accumulator/remainder, operand.
  - Outputs: next accumulator and next quotient bit.
  - Instanced once inside mips_muldiv, which owns all registers and the FSM.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done in cycle after edge k+33, hi=0xFFFFFFFE, lo=0x00000001. busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=100 b=7 -> lo=14, hi=2, div_zero=0.
- DIVU a=0x12345678 b=0 -> hi=0x12345678, lo=0xFFFFFFFF, div_zero=1 with done. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- During a MULTU 6*7: pulse start with different operands, and hi_we with wdata=0xDEADBEEF -> both ignored, final hi=0, lo=42. Afterwards in IDLE, hi_we/lo_we with 0xDEADBEEF -> hi=lo=0xDEADBEEF next cycle.
- Assert rst_n=0 for one cycle at RUN iteration 10 -> next cycle hi=lo=0, busy=0, and no done pulse. A new start then completes normally after 34 cycles.
